// File: rtl/condicionador_entradas_pkg.sv
// Shared definitions for the input-conditioning slice that sits in front of neurosync.
//   N_BOTOES_PADRAO  default number of game buttons
//   DEBOUNCE_PADRAO  default filter length in clocks (1 ms at 50 MHz)
//   MAX_BOTOES       widest button vector the multi-press helper accepts
//   mais_de_um()     true when more than one bit of the vector is set
package condicionador_entradas_pkg;

    localparam int unsigned N_BOTOES_PADRAO = 4;
    localparam int unsigned DEBOUNCE_PADRAO = 50000;
    localparam int unsigned MAX_BOTOES      = 32;

    // Clearing the lowest set bit leaves something only if two or more bits were set.
    function automatic logic mais_de_um(input logic [MAX_BOTOES-1:0] v);
        return (v & (v - 32'd1)) != '0;
    endfunction

endpackage

// File: rtl/condicionador_entradas_if.sv
// Bundle of raw board pins and conditioned outputs for condicionador_entradas.
//   botoes_raw/jogar_raw/confirma_raw/nivel_raw : raw pins (driven by the board side)
//   botoes/jogar/confirma/nivel/multiplo/db_estavel : conditioned outputs
//   master : board/stimulus side, slave : conditioner side
interface condicionador_entradas_if
    import condicionador_entradas_pkg::*;
#(
    parameter int unsigned N_BOTOES = N_BOTOES_PADRAO
);

    logic [N_BOTOES-1:0] botoes_raw;
    logic                jogar_raw;
    logic                confirma_raw;
    logic                nivel_raw;

    logic [N_BOTOES-1:0] botoes;
    logic                jogar;
    logic                confirma;
    logic                nivel;
    logic                multiplo;
    logic                db_estavel;

    modport master (
        output botoes_raw, jogar_raw, confirma_raw, nivel_raw,
        input  botoes, jogar, confirma, nivel, multiplo, db_estavel
    );

    modport slave (
        input  botoes_raw, jogar_raw, confirma_raw, nivel_raw,
        output botoes, jogar, confirma, nivel, multiplo, db_estavel
    );

endinterface

// File: rtl/condicionador_entradas_debouncer.sv
// Single-input conditioner: 2-flop synchroniser, optional polarity inversion,
// and a consecutive-stable-cycle filter holding the debounced level.
//   clock       system clock, rising edge
//   reset       asynchronous, active-low
//   entrada_raw raw asynchronous pin
//   nivel       debounced level (d)
//   ocupado     high while the filter counter is non-zero
module condicionador_entradas_debouncer
    import condicionador_entradas_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter bit          ATIVO_BAIXO     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic entrada_raw,
    output logic nivel,
    output logic ocupado
);

    localparam int unsigned CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
    localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

    logic          sync_1;
    logic          sync_2;
    logic          amostra;
    logic [CW-1:0] cnt;
    logic          d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= entrada_raw;
            sync_2 <= sync_1;
        end
    end

    assign amostra = ATIVO_BAIXO ? ~sync_2 : sync_2;

    // Any cycle where the sample agrees with d throws the partial count away,
    // so only an unbroken run of DEBOUNCE_CICLOS mismatches flips d.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            d   <= 1'b0;
        end else if (amostra == d) begin
            cnt <= '0;
        end else if (cnt == CNT_FIM) begin
            d   <= amostra;
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign nivel   = d;
    assign ocupado = (cnt != '0);

endmodule

// File: rtl/condicionador_entradas.sv
// Conditions raw board inputs before they reach neurosync (same clock domain).
//   clock  system clock, rising edge
//   reset  asynchronous, active-low
//   bus    condicionador_entradas_if.slave:
//          raw pins in; botoes (debounced, zero on multi-press), jogar/confirma
//          (one-clock pulses per accepted press), nivel (debounced level),
//          multiplo (more than one button held), db_estavel (no filter active)
module condicionador_entradas
    import condicionador_entradas_pkg::*;
#(
    parameter int unsigned N_BOTOES        = N_BOTOES_PADRAO,
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
    parameter bit          ATIVO_BAIXO     = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    condicionador_entradas_if.slave bus
);

    localparam int unsigned N_ENTRADAS = N_BOTOES + 3;

    logic [N_BOTOES-1:0]   d_botoes;
    logic                  d_jogar;
    logic                  d_confirma;
    logic                  d_nivel;
    logic [N_ENTRADAS-1:0] ocupado;

    logic [N_BOTOES-1:0]   botoes_q;
    logic                  multiplo_q;
    logic                  jogar_q;
    logic                  confirma_q;
    logic                  nivel_q;
    logic                  jogar_ant;
    logic                  confirma_ant;

    logic [MAX_BOTOES-1:0] botoes_ext;
    logic                  multi;

    genvar g;
    generate
        for (g = 0; g < N_BOTOES; g++) begin : g_botao
            condicionador_entradas_debouncer #(
                .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
                .ATIVO_BAIXO     (ATIVO_BAIXO)
            ) u_db (
                .clock       (clock),
                .reset       (reset),
                .entrada_raw (bus.botoes_raw[g]),
                .nivel       (d_botoes[g]),
                .ocupado     (ocupado[g])
            );
        end
    endgenerate

    condicionador_entradas_debouncer #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .ATIVO_BAIXO     (ATIVO_BAIXO)
    ) u_db_jogar (
        .clock       (clock),
        .reset       (reset),
        .entrada_raw (bus.jogar_raw),
        .nivel       (d_jogar),
        .ocupado     (ocupado[N_BOTOES])
    );

    condicionador_entradas_debouncer #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .ATIVO_BAIXO     (ATIVO_BAIXO)
    ) u_db_confirma (
        .clock       (clock),
        .reset       (reset),
        .entrada_raw (bus.confirma_raw),
        .nivel       (d_confirma),
        .ocupado     (ocupado[N_BOTOES+1])
    );

    condicionador_entradas_debouncer #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .ATIVO_BAIXO     (ATIVO_BAIXO)
    ) u_db_nivel (
        .clock       (clock),
        .reset       (reset),
        .entrada_raw (bus.nivel_raw),
        .nivel       (d_nivel),
        .ocupado     (ocupado[N_BOTOES+2])
    );

    always_comb begin
        botoes_ext              = '0;
        botoes_ext[N_BOTOES-1:0] = d_botoes;
        multi                   = mais_de_um(botoes_ext);
    end

    // Pulses compare d against its value one clock earlier, so a press yields
    // exactly one high clock right after d rises and nothing while held or on release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            botoes_q     <= '0;
            multiplo_q   <= 1'b0;
            jogar_q      <= 1'b0;
            confirma_q   <= 1'b0;
            nivel_q      <= 1'b0;
            jogar_ant    <= 1'b0;
            confirma_ant <= 1'b0;
        end else begin
            jogar_ant    <= d_jogar;
            confirma_ant <= d_confirma;
            jogar_q      <= d_jogar & ~jogar_ant;
            confirma_q   <= d_confirma & ~confirma_ant;
            nivel_q      <= d_nivel;
            if (multi) begin
                botoes_q   <= '0;
                multiplo_q <= 1'b1;
            end else begin
                botoes_q   <= d_botoes;
                multiplo_q <= 1'b0;
            end
        end
    end

    assign bus.botoes     = botoes_q;
    assign bus.multiplo   = multiplo_q;
    assign bus.jogar      = jogar_q;
    assign bus.confirma   = confirma_q;
    assign bus.nivel      = nivel_q;
    assign bus.db_estavel = ~|ocupado;

endmodule

// File: tb/tb_condicionador_entradas.sv
// Self-checking bench for condicionador_entradas with DEBOUNCE_CICLOS=4, ATIVO_BAIXO=0.
// Observed vector layout: {botoes[3:0], jogar, confirma, nivel, multiplo, db_estavel}.
module tb_condicionador_entradas;

    logic clock;
    logic reset;

    int checks   = 0;
    int failures = 0;

    condicionador_entradas_if #(.N_BOTOES(4)) bus ();

    condicionador_entradas #(
        .N_BOTOES        (4),
        .DEBOUNCE_CICLOS (4),
        .ATIVO_BAIXO     (1'b0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [8:0] obs;
    assign obs = {bus.botoes, bus.jogar, bus.confirma, bus.nivel, bus.multiplo, bus.db_estavel};

    typedef struct {
        logic [3:0]  botoes_raw;
        logic        jogar_raw;
        logic        confirma_raw;
        logic        nivel_raw;
        int unsigned ciclos;
        logic [8:0]  esperado;
        string       nome;
    } vetor_t;

    typedef struct {
        logic [8:0] esperado;
        string      nome;
    } esp_t;

    vetor_t tabela[$];
    esp_t   placar[$];

    function automatic logic [8:0] esp(input logic [3:0] b, input logic j, input logic c,
                                       input logic n, input logic m, input logic e);
        return {b, j, c, n, m, e};
    endfunction

    function automatic void add(input logic [3:0] b, input logic j, input logic c, input logic n,
                                input int unsigned ciclos, input logic [8:0] e, input string nome);
        vetor_t v;
        v.botoes_raw   = b;
        v.jogar_raw    = j;
        v.confirma_raw = c;
        v.nivel_raw    = n;
        v.ciclos       = ciclos;
        v.esperado     = e;
        v.nome         = nome;
        tabela.push_back(v);
    endfunction

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic verifica(input string nome, input logic [8:0] real_v, input logic [8:0] esp_v);
        checks++;
        if (real_v !== esp_v) begin
            failures++;
            $display("FAIL %s: obtido=%b esperado=%b", nome, real_v, esp_v);
        end
    endtask

    task automatic aplica(input logic [3:0] b, input logic j, input logic c, input logic n);
        bus.botoes_raw   = b;
        bus.jogar_raw    = j;
        bus.confirma_raw = c;
        bus.nivel_raw    = n;
    endtask

    initial begin
        esp_t e;

        // Reset with every raw input high: outputs stay cleared while reset is held.
        reset = 1'b0;
        aplica(4'b1111, 1'b1, 1'b1, 1'b1);
        tick(3);
        verifica("reset_entradas_altas", obs, esp(4'b0000, 0, 0, 0, 0, 1));
        tick(3);
        verifica("reset_mantido", obs, esp(4'b0000, 0, 0, 0, 0, 1));
        aplica(4'b0000, 1'b0, 1'b0, 1'b0);
        tick(2);
        reset = 1'b1;
        tick(4);
        verifica("pos_reset", obs, esp(4'b0000, 0, 0, 0, 0, 1));

        // jogar: accepted after 6 clocks, pulse on clock 7 only
        add(4'b0000, 1, 0, 0, 3,  esp(4'b0000, 0, 0, 0, 0, 0), "jogar_meio_filtro");
        add(4'b0000, 1, 0, 0, 3,  esp(4'b0000, 0, 0, 0, 0, 1), "jogar_aceito");
        add(4'b0000, 1, 0, 0, 1,  esp(4'b0000, 1, 0, 0, 0, 1), "jogar_pulso");
        add(4'b0000, 1, 0, 0, 1,  esp(4'b0000, 0, 0, 0, 0, 1), "jogar_fim_pulso");
        add(4'b0000, 1, 0, 0, 12, esp(4'b0000, 0, 0, 0, 0, 1), "jogar_segurado");
        add(4'b0000, 0, 0, 0, 10, esp(4'b0000, 0, 0, 0, 0, 1), "jogar_solto");
        // single button with a 3-clock glitch that restarts the count
        add(4'b0100, 0, 0, 0, 3,  esp(4'b0000, 0, 0, 0, 0, 0), "botao_meio");
        add(4'b0000, 0, 0, 0, 3,  esp(4'b0000, 0, 0, 0, 0, 1), "botao_glitch");
        add(4'b0100, 0, 0, 0, 3,  esp(4'b0000, 0, 0, 0, 0, 0), "botao_reinicio");
        add(4'b0100, 0, 0, 0, 3,  esp(4'b0000, 0, 0, 0, 0, 1), "botao_quase");
        add(4'b0100, 0, 0, 0, 1,  esp(4'b0100, 0, 0, 0, 0, 1), "botao_aceito");
        add(4'b0000, 0, 0, 0, 7,  esp(4'b0000, 0, 0, 0, 0, 1), "botao_solto");
        // multi-press rejection and return to a single button
        add(4'b0011, 0, 0, 0, 7,  esp(4'b0000, 0, 0, 0, 1, 1), "multiplo");
        add(4'b0001, 0, 0, 0, 6,  esp(4'b0000, 0, 0, 0, 1, 1), "multiplo_filtro");
        add(4'b0001, 0, 0, 0, 1,  esp(4'b0001, 0, 0, 0, 0, 1), "volta_unico");
        add(4'b0000, 0, 0, 0, 7,  esp(4'b0000, 0, 0, 0, 0, 1), "botoes_soltos");
        // jogar and confirma accepted together pulse together
        add(4'b0000, 1, 1, 0, 6,  esp(4'b0000, 0, 0, 0, 0, 1), "simult_aceito");
        add(4'b0000, 1, 1, 0, 1,  esp(4'b0000, 1, 1, 0, 0, 1), "simult_pulso");
        add(4'b0000, 1, 1, 0, 1,  esp(4'b0000, 0, 0, 0, 0, 1), "simult_fim");
        add(4'b0000, 0, 0, 0, 8,  esp(4'b0000, 0, 0, 0, 0, 1), "simult_solto");
        // nivel level follows after 7 clocks
        add(4'b0000, 0, 0, 1, 6,  esp(4'b0000, 0, 0, 0, 0, 1), "nivel_filtro");
        add(4'b0000, 0, 0, 1, 1,  esp(4'b0000, 0, 0, 1, 0, 1), "nivel_aceito");

        for (int i = 0; i < tabela.size(); i++) begin
            aplica(tabela[i].botoes_raw, tabela[i].jogar_raw, tabela[i].confirma_raw, tabela[i].nivel_raw);
            e.esperado = tabela[i].esperado;
            e.nome     = tabela[i].nome;
            placar.push_back(e);
            tick(tabela[i].ciclos);
            if (placar.size() == 0) begin
                failures++;
                $display("FAIL placar_vazio: obtido=%b esperado=entrada", obs);
            end else begin
                e = placar.pop_front();
                verifica(e.nome, obs, e.esperado);
            end
        end

        // Asynchronous reset while nivel is held: clears at once, re-accepted 7 clocks after release.
        #3 reset = 1'b0;
        #1 verifica("reset_async_nivel", obs, esp(4'b0000, 0, 0, 0, 0, 1));
        tick(2);
        verifica("reset_segurado_nivel", obs, esp(4'b0000, 0, 0, 0, 0, 1));
        reset = 1'b1;
        tick(6);
        verifica("nivel_pos_reset_filtro", obs, esp(4'b0000, 0, 0, 0, 0, 1));
        tick(1);
        verifica("nivel_pos_reset_aceito", obs, esp(4'b0000, 0, 0, 1, 0, 1));

        // confirma bouncing in 2-clock bursts never gets through; db_estavel follows the bursts.
        for (int k = 0; k < 20; k++) begin
            int unsigned fase;
            logic        est;
            bus.confirma_raw = ((k % 4) < 2);
            tick(1);
            fase = (k + 1) % 4;
            est  = (fase == 1) || (fase == 2);
            verifica("confirma_rajada", obs, esp(4'b0000, 0, 0, 1, 0, est));
        end
        bus.confirma_raw = 1'b0;
        tick(10);
        verifica("confirma_repouso", obs, esp(4'b0000, 0, 0, 1, 0, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
